// File: rtl/framed_shift_register_pkg.sv
// Shared constants and helpers for the framed SPI-style shift register.
package shift_pkg;

    localparam logic MSB_FIRST = 1'b1;
    localparam logic LSB_FIRST = 1'b0;

    // A counter for a 2-bit frame still needs one bit, so never return 0.
    function automatic int clog2Min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/framed_shift_register_if.sv
// Control and data bundle between the SPI edge logic and the shift register.
interface framed_shift_register_if
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = clog2Min1(WIDTH)
);
    logic             enable;
    logic             sampleEdge;
    logic             shiftEdge;
    logic             parallelLoad;
    logic [WIDTH-1:0] parallelDataIn;
    logic             msbFirst;
    logic             serialDataIn;
    logic             serialDataOut;
    logic [WIDTH-1:0] parallelDataOut;
    logic [CNT_W-1:0] bitCount;
    logic             frameDone;

    modport master (
        output enable, sampleEdge, shiftEdge, parallelLoad, parallelDataIn,
               msbFirst, serialDataIn,
        input  serialDataOut, parallelDataOut, bitCount, frameDone
    );

    modport slave (
        input  enable, sampleEdge, shiftEdge, parallelLoad, parallelDataIn,
               msbFirst, serialDataIn,
        output serialDataOut, parallelDataOut, bitCount, frameDone
    );
endinterface

// File: rtl/framed_shift_register_frame_bit_counter.sv
// Counts samples within a frame and flags the sample that completes it.
module frame_bit_counter
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = clog2Min1(WIDTH)
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    assign wrap = inc && (count == LAST);

    always_ff @(posedge clk) begin
        if (!resetN)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc)
            count <= wrap ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/framed_shift_register.sv
// WIDTH-bit framed shift register with selectable bit order and split sample/shift strobes.
module framed_shift_register
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = clog2Min1(WIDTH)
) (
    input logic                clk,
    input logic                resetN,
    framed_shift_register_if.slave bus
);
    logic [WIDTH-1:0] mem;
    logic [WIDTH-1:0] shiftedMem;
    logic             txBit;
    logic             loadBit;
    logic             sampleTaken;
    logic             counterClear;
    logic             frameWrap;

    // Load and idle both restart framing, and both mask the strobes.
    assign counterClear = bus.parallelLoad || !bus.enable;
    assign sampleTaken  = bus.enable && !bus.parallelLoad && bus.sampleEdge;

    always_comb begin
        shiftedMem = mem;
        txBit      = mem[0];
        loadBit    = bus.parallelDataIn[0];
        if (bus.msbFirst == MSB_FIRST) begin
            shiftedMem = {mem[WIDTH-2:0], bus.serialDataIn};
            txBit      = mem[WIDTH-1];
            loadBit    = bus.parallelDataIn[WIDTH-1];
        end else begin
            shiftedMem = {bus.serialDataIn, mem[WIDTH-1:1]};
        end
    end

    frame_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) uCounter (
        .clk    (clk),
        .resetN (resetN),
        .clear  (counterClear),
        .inc    (sampleTaken),
        .count  (bus.bitCount),
        .wrap   (frameWrap)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            mem                 <= '0;
            bus.serialDataOut   <= 1'b0;
            bus.parallelDataOut <= '0;
            bus.frameDone       <= 1'b0;
        end else if (bus.parallelLoad) begin
            mem               <= bus.parallelDataIn;
            bus.serialDataOut <= loadBit;
            bus.frameDone     <= 1'b0;
        end else if (!bus.enable) begin
            bus.frameDone <= 1'b0;
        end else begin
            if (bus.sampleEdge)
                mem <= shiftedMem;
            // txBit is taken from mem before this cycle's sample shifts it.
            if (bus.shiftEdge)
                bus.serialDataOut <= txBit;
            if (frameWrap)
                bus.parallelDataOut <= shiftedMem;
            bus.frameDone <= frameWrap;
        end
    end
endmodule

// File: doc/framed_shift_register.md
Name: framed_shift_register

Overview:
- Next-generation SPI-style shift register. Parametrised width, runtime-selectable bit order, and independent sample/shift strobes so serial-in and serial-out can occur on opposite peripheral clock edges.
- A bit counter frames each WIDTH-bit transfer and pulses frameDone with a stable received word.
- Sits between the peripheral edge detector and the register file or command FSM in the SPI datapath.

Parameters:
- WIDTH, 8, frame and register width in bits; must be >= 2.
- CNT_W, $clog2(WIDTH), bit-counter width; derived value, not to be overridden.

Ports:
- clk  in  1  FPGA clock; all logic on posedge.
- resetN  in  1  synchronous reset, active low.
- enable  in  1  frame active (chip-select equivalent); low means idle.
- sampleEdge  in  1  one-cycle strobe: capture serialDataIn.
- shiftEdge  in  1  one-cycle strobe: advance serialDataOut to the next bit.
- parallelLoad  in  1  load parallelDataIn; restarts the frame.
- parallelDataIn  in  WIDTH  word to transmit.
- msbFirst  in  1  1 = MSB first, 0 = LSB first; sampled every cycle.
- serialDataIn  in  1  serial receive bit.
- serialDataOut  out  1  registered transmit bit.
- parallelDataOut  out  WIDTH  last completed received word.
- bitCount  out  CNT_W  samples taken in the current frame (0..WIDTH-1).
- frameDone  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (resetN).
- Reset (resetN=0 at posedge): internal mem=0, serialDataOut=0, parallelDataOut=0, bitCount=0, frameDone=0. Reset overrides every other input, including mid-frame.
- Priority per cycle: reset > parallelLoad > !enable > strobes.
- parallelLoad=1:
  - mem <= parallelDataIn, bitCount <= 0.
  - serialDataOut <= msbFirst ? parallelDataIn[WIDTH-1] : parallelDataIn[0], so the first bit is valid before the first edge.
  - Strobes in the same cycle are ignored. Allowed regardless of enable.
- enable=0 (no load): bitCount <= 0; mem, serialDataOut and parallelDataOut hold; strobes ignored; frameDone=0.
- sampleEdge=1 (enabled):
  - msbFirst=1: mem <= {mem[WIDTH-2:0], serialDataIn}.
  - msbFirst=0: mem <= {serialDataIn, mem[WIDTH-1:1]}.
  - bitCount increments.
- Frame completion: on the sampleEdge taken with bitCount==WIDTH-1:
  - bitCount wraps to 0.
  - parallelDataOut <= the post-shift word.
  - frameDone <= 1.
  - Both outputs are visible the cycle after the strobe. frameDone is high for exactly one cycle unless another completion follows.
- shiftEdge=1 (enabled): serialDataOut <= msbFirst ? mem[WIDTH-1] : mem[0], using the pre-update mem value.
- sampleEdge and shiftEdge in the same cycle: both act; shiftEdge reads mem before this cycle's shift.
- Loopback (serialDataOut tied to serialDataIn, sample then shift alternating) returns the loaded word in parallelDataOut after WIDTH samples.
- msbFirst change mid-frame: legal. Takes effect on the next strobe; no reset of counter or data.
- Back-to-back frames: the next sample after completion starts a new frame at bitCount=0. No idle cycle is required.
- serialDataOut changes only on parallelLoad, shiftEdge or reset (glitch-free, registered).

Decomposition:
- Package shift_pkg:
  - MSB_FIRST=1'b1 and LSB_FIRST=1'b0 constants.
  - a clog2-with-minimum-1 function used for CNT_W.
- One sub-module, frame_bit_counter:
  - ports: clk, resetN, clear, inc.
  - outputs: count, wrap (wrap = inc && count==WIDTH-1).
- Datapath and serial-out logic stay in the top module.

Test Plan:
- Reset: hold resetN=0 two cycles with random inputs -> all outputs 0. Release; no strobes -> outputs hold 0.
- MSB-first loopback, WIDTH=8:
  - Stimulus: load 0xA5, serialDataOut looped to serialDataIn, 8 alternating sample/shift pairs.
  - serialDataOut sequence: 1,0,1,0,0,1,0,1.
  - frameDone pulses once; parallelDataOut=0xA5.
- LSB-first receive:
  - Stimulus: msbFirst=0, drive serialDataIn 1,1,0,0,0,0,0,0 on 8 sampleEdges.
  - parallelDataOut=0x03, bitCount 0→7→0.
- Load mid-frame:
  - Stimulus: after 3 samples, assert parallelLoad with sampleEdge in the same cycle.
  - bitCount=0; mem=parallelDataIn; the sample is ignored; no frameDone.
- enable drop mid-frame:
  - Stimulus: deassert enable after 5 samples, reassert, then 8 samples.
  - Exactly one frameDone, after the 8th post-reassert sample.
- Reset mid-frame plus WIDTH=16 build:
  - Stimulus: resetN=0 after 4 samples.
  - All outputs 0 next cycle.
  - A subsequent 16-bit loopback of 0xBEEF completes with frameDone.
